interrupt_arbiter: RTL and testbench
====================================

Name: interrupt_arbiter

Overview:
Synchronous interrupt controller that sits between the device interrupt lines and the CPU control unit. It detects request edges, holds them as pending, applies the mask and the global enable, and picks one winner by priority. It raises a single request to the microcode sequencer, hands it the vector and IRQ number on acknowledge, and tracks the in-service line until end-of-interrupt. This replaces the free-running latch-per-line scheme with a sequenced, arbitrated one.

Parameters:
N_IRQ, 5, number of interrupt lines; legal range 1..8.
VEC_BASE, 8'hF0, vector address for line 0.
VEC_STRIDE, 2, vector spacing between consecutive lines.

Ports:
clk  input  1  system clock; all state changes on posedge.
rst  input  1  asynchronous reset, active-high.
irq_in  input  N_IRQ  device request lines; a rising edge requests service.
mask  input  N_IRQ  per-line mask; 1 blocks arbitration of that line, but its pending bit is still recorded.
int_en_set  input  1  one-cycle strobe that sets the global enable.
int_en_clr  input  1  one-cycle strobe that clears the global enable.
int_ack  input  1  sequencer accepts the current request.
eoi  input  1  end-of-interrupt strobe from the handler.
int_req  output  1  request to the sequencer.
int_vec  output  8  vector of the selected line; valid while int_req=1.
irq_no  output  N_IRQ  one-hot in-service line.
pending  output  N_IRQ  pending bits, for software visibility.
int_en  output  1  global enable state.

Behaviour:
- Reset values: int_req=0, int_vec=8'h00, irq_no=0, pending=0, int_en=1, state=IDLE.
- Reset also clears the edge register irq_q to 0, so a line held high through reset release registers one edge.
- Reset mid-service drops the in-service line with no eoi required.
- Edge detect: irq_q <= irq_in every cycle. rise[i] = irq_in[i] & ~irq_q[i].
- Pending set: pending[i] <= 1 at the edge where rise[i]=1.
- Pending clear: pending[i] is cleared only by int_ack for the selected line.
- If rise and ack-clear hit the same bit in the same cycle, set wins; the new edge is kept.
- Global enable: int_en_clr has priority over int_en_set when both are asserted.
- On int_ack the enable clears automatically: int_en <= 0.
- Eligible set: elig = pending & ~mask, gated by int_en.
- Selection: fixed priority, lowest index wins.
- Vector: int_vec = VEC_BASE + sel*VEC_STRIDE, truncated to 8 bits (wraps mod 256).
- FSM states: IDLE, REQ, SERVICE.
- IDLE: if int_en and |elig, latch sel and int_vec, assert int_req, go to REQ. Otherwise stay in IDLE.
- IDLE ignores int_ack and eoi.
- REQ: int_req held at 1 and sel frozen, even if the mask or enable changes or a higher-priority line arrives. The request is never withdrawn.
- REQ on int_ack: clear pending[sel], set irq_no to one-hot(sel), drop int_req, go to SERVICE.
- REQ ignores eoi.
- SERVICE: int_req=0. New edges keep accumulating in pending. No nesting.
- SERVICE on eoi: irq_no <= 0, go to IDLE. SERVICE ignores int_ack.
- Latency: rising edge sampled at posedge N gives pending=1 after N, and int_req=1 after N+1 if eligible.
- Latency: int_ack sampled at posedge M gives int_req=0 and irq_no valid after M.
- Back-to-back: after eoi, the next request needs int_en to be set again by software. The earliest re-request is 1 cycle after the edge that samples both int_en=1 and eoi.
- int_vec is held at its last value outside REQ.

Optional Feature:
INT_ARB_ROUND_ROBIN_EN:
- With the macro defined, a last-granted index register (reset to N_IRQ-1) is added. Selection picks the first eligible line scanning upward from last+1, with wrap-around, and last is updated on int_ack.
- Without the macro, fixed priority applies (lowest index wins) and the register is not present.

Test Plan:
1. Reset release with irq_in=5'b00000; pulse irq_in[2] for 1 cycle -> pending=5'b00100 next cycle, int_req=1 the cycle after, int_vec=8'hF4. Assert int_ack -> irq_no=5'b00100, pending=0, int_en=0.
2. Edges on irq_in[3] and irq_in[1] in the same cycle -> int_vec=8'hF2 (line 1). After ack, eoi and int_en_set -> second request with int_vec=8'hF6 (line 3).
3. mask=5'b00001 and pulse on irq_in[0] -> pending=5'b00001, int_req stays 0. Clear mask -> int_req=1 with int_vec=8'hF0.
4. While in REQ, int_en_clr plus a new edge on line 0 -> int_req stays 1 and int_vec unchanged. int_en_set and int_en_clr together -> int_en=0.
5. Assert rst asynchronously during SERVICE (irq_no=5'b01000) -> all outputs take reset values immediately, int_en=1. A line still high at release -> pending bit set one cycle later.
6. With INT_ARB_ROUND_ROBIN_EN defined: lines 0 and 1 pending, grant line 0, then re-pend 0 -> next grant goes to line 1 (int_vec=8'hF2).

Source files
------------

// File: rtl/interrupt_arbiter_if.sv
// interrupt_arbiter_if: device, mask, enable and sequencer handshake bundle for interrupt_arbiter
interface interrupt_arbiter_if #(
    parameter int N_IRQ = 5
);
    logic [N_IRQ-1:0] irq_in;
    logic [N_IRQ-1:0] mask;
    logic             int_en_set;
    logic             int_en_clr;
    logic             int_ack;
    logic             eoi;
    logic             int_req;
    logic [7:0]       int_vec;
    logic [N_IRQ-1:0] irq_no;
    logic [N_IRQ-1:0] pending;
    logic             int_en;

    modport master (
        output irq_in, mask, int_en_set, int_en_clr, int_ack, eoi,
        input  int_req, int_vec, irq_no, pending, int_en
    );

    modport slave (
        input  irq_in, mask, int_en_set, int_en_clr, int_ack, eoi,
        output int_req, int_vec, irq_no, pending, int_en
    );
endinterface

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: edge-detecting, masked, prioritised interrupt controller with REQ/ack/eoi sequencing.
// Define INT_ARB_ROUND_ROBIN_EN for rotating priority instead of lowest-index-wins.
module interrupt_arbiter #(
    parameter int         N_IRQ      = 5,
    parameter logic [7:0] VEC_BASE   = 8'hF0,
    parameter int         VEC_STRIDE = 2
) (
    input logic                 clk,
    input logic                 rst,
    interrupt_arbiter_if.slave  bus
);
    localparam int SW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state;
    logic [N_IRQ-1:0] irq_q, rise, elig, ack_clr;
    logic [SW-1:0]    sel, sel_q;
    logic [7:0]       vec;
    logic             found, ack;

    assign rise    = bus.irq_in & ~irq_q;
    assign elig    = bus.int_en ? (bus.pending & ~bus.mask) : '0;
    assign ack     = (state == REQ) && bus.int_ack;
    assign ack_clr = ack ? (N_IRQ'(1) << sel_q) : '0;
    assign vec     = VEC_BASE + 8'(int'(sel) * VEC_STRIDE);

`ifdef INT_ARB_ROUND_ROBIN_EN
    logic [SW-1:0] last_q, idx;

    // Scan downward so the first eligible line after last_q is assigned last and wins
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            idx = SW'((int'(last_q) + 1 + k) % N_IRQ);
            if (elig[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) last_q <= SW'(N_IRQ - 1);
        else if (ack) last_q <= sel_q;
`else
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (elig[i]) begin
                sel   = SW'(i);
                found = 1'b1;
            end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            irq_q       <= '0;
            sel_q       <= '0;
            bus.pending <= '0;
            bus.int_en  <= 1'b1;
            bus.int_req <= 1'b0;
            bus.int_vec <= 8'h00;
            bus.irq_no  <= '0;
        end else begin
            irq_q       <= bus.irq_in;
            bus.pending <= (bus.pending & ~ack_clr) | rise;
            bus.int_en  <= (ack || bus.int_en_clr) ? 1'b0 : (bus.int_en_set ? 1'b1 : bus.int_en);
            unique case (state)
                IDLE:
                    if (found) begin
                        state       <= REQ;
                        sel_q       <= sel;
                        bus.int_vec <= vec;
                        bus.int_req <= 1'b1;
                    end
                REQ:
                    if (bus.int_ack) begin
                        state       <= SERVICE;
                        bus.int_req <= 1'b0;
                        bus.irq_no  <= N_IRQ'(1) << sel_q;
                    end
                SERVICE:
                    if (bus.eoi) begin
                        state      <= IDLE;
                        bus.irq_no <= '0;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb_interrupt_arbiter: directed bench with a vector scoreboard for interrupt_arbiter.
module tb_interrupt_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;
    logic [7:0] sbq[$];

    interrupt_arbiter_if #(.N_IRQ(5)) bus();

    interrupt_arbiter #(.N_IRQ(5), .VEC_BASE(8'hF0), .VEC_STRIDE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request and compare its vector against the scoreboard head
    task automatic wait_req(string tag);
        int n = 0;
        logic [7:0] e;
        while (!bus.int_req && n < 20) begin
            tick();
            n++;
        end
        e = (sbq.size() != 0) ? sbq.pop_front() : 8'hxx;
        check({tag, "_req"}, 32'(bus.int_req), 32'd1);
        check({tag, "_vec"}, 32'(bus.int_vec), 32'(e));
    endtask

    task automatic pulse_irq(logic [4:0] lines);
        bus.irq_in = lines;
        tick();
        bus.irq_in = '0;
    endtask

    task automatic do_ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic do_eoi_set();
        bus.eoi        = 1'b1;
        bus.int_en_set = 1'b1;
        tick();
        bus.eoi        = 1'b0;
        bus.int_en_set = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.irq_in     = '0;
        bus.mask       = '0;
        bus.int_en_set = 1'b0;
        bus.int_en_clr = 1'b0;
        bus.int_ack    = 1'b0;
        bus.eoi        = 1'b0;
        #12;
        check("rst_req", 32'(bus.int_req), 32'd0);
        check("rst_vec", 32'(bus.int_vec), 32'h00);
        check("rst_irq_no", 32'(bus.irq_no), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_int_en", 32'(bus.int_en), 32'd1);
        rst = 1'b0;
        tick();

        // single line, exact latency
        bus.irq_in = 5'b00100;
        sbq.push_back(8'hF4);
        tick();
        bus.irq_in = '0;
        check("t1_pending", 32'(bus.pending), 32'b00100);
        check("t1_req_early", 32'(bus.int_req), 32'd0);
        tick();
        check("t1_req_lat", 32'(bus.int_req), 32'd1);
        wait_req("t1");
        do_ack();
        check("t1_irq_no", 32'(bus.irq_no), 32'b00100);
        check("t1_pending_clr", 32'(bus.pending), 32'd0);
        check("t1_int_en", 32'(bus.int_en), 32'd0);
        check("t1_req_drop", 32'(bus.int_req), 32'd0);

        // simultaneous edges, lowest index first; eoi without enable does not re-request
        pulse_irq(5'b01010);
        sbq.push_back(8'hF2);
        sbq.push_back(8'hF6);
        check("t2_pending", 32'(bus.pending), 32'b01010);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        check("t2_eoi_irq_no", 32'(bus.irq_no), 32'd0);
        tick();
        check("t2_no_req_disabled", 32'(bus.int_req), 32'd0);
        bus.int_en_set = 1'b1;
        tick();
        bus.int_en_set = 1'b0;
        check("t2_int_en", 32'(bus.int_en), 32'd1);
        wait_req("t2a");
        do_ack();
        check("t2_irq_no_a", 32'(bus.irq_no), 32'b00010);
        check("t2_pending_a", 32'(bus.pending), 32'b01000);
        do_eoi_set();
        check("t2_b2b_idle", 32'(bus.int_req), 32'd0);
        tick();
        check("t2_b2b_req", 32'(bus.int_req), 32'd1);
        wait_req("t2b");
        do_ack();
        check("t2_irq_no_b", 32'(bus.irq_no), 32'b01000);
        do_eoi_set();

        // masked line records pending but is not arbitrated
        bus.mask = 5'b00001;
        pulse_irq(5'b00001);
        check("t3_pending", 32'(bus.pending), 32'b00001);
        tick();
        tick();
        check("t3_masked_req", 32'(bus.int_req), 32'd0);
        bus.mask = '0;
        sbq.push_back(8'hF0);
        tick();
        wait_req("t3");

        // REQ is frozen against disable, mask and new higher-priority edges
        bus.int_en_clr = 1'b1;
        bus.irq_in     = 5'b00001;
        bus.mask       = 5'b00001;
        tick();
        bus.int_en_clr = 1'b0;
        check("t4_req_held", 32'(bus.int_req), 32'd1);
        check("t4_vec_held", 32'(bus.int_vec), 32'hF0);
        check("t4_int_en_clr", 32'(bus.int_en), 32'd0);
        bus.int_en_set = 1'b1;
        tick();
        check("t4_int_en_set", 32'(bus.int_en), 32'd1);
        bus.int_en_clr = 1'b1;
        bus.irq_in     = '0;
        bus.mask       = '0;
        tick();
        bus.int_en_set = 1'b0;
        bus.int_en_clr = 1'b0;
        check("t4_clr_wins", 32'(bus.int_en), 32'd0);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        check("t4_eoi_ignored", 32'(bus.int_req), 32'd1);
        // a fresh edge on the line being acked survives the ack clear
        bus.irq_in  = 5'b00001;
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        bus.irq_in  = '0;
        check("t4_irq_no", 32'(bus.irq_no), 32'b00001);
        check("t4_set_wins", 32'(bus.pending), 32'b00001);
        check("t4_ack_ignored_svc", 32'(bus.irq_no), 32'b00001);

        // async reset mid-service
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        bus.int_en_set = 1'b1;
        tick();
        bus.int_en_set = 1'b0;
        sbq.delete();
        sbq.push_back(8'hF0);
        wait_req("t5pre0");
        do_ack();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        bus.int_en_set = 1'b1;
        bus.irq_in     = 5'b01000;
        sbq.push_back(8'hF6);
        tick();
        bus.int_en_set = 1'b0;
        bus.irq_in     = '0;
        wait_req("t5pre3");
        do_ack();
        check("t5_svc_irq_no", 32'(bus.irq_no), 32'b01000);
        bus.irq_in = 5'b10000;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_irq_no", 32'(bus.irq_no), 32'd0);
        check("t5_async_pending", 32'(bus.pending), 32'd0);
        check("t5_async_int_en", 32'(bus.int_en), 32'd1);
        check("t5_async_req", 32'(bus.int_req), 32'd0);
        check("t5_async_vec", 32'(bus.int_vec), 32'h00);
        tick();
        rst = 1'b0;
        tick();
        check("t5_held_line_pending", 32'(bus.pending), 32'b10000);
        sbq.push_back(8'hF8);
        wait_req("t5post");
        bus.irq_in = '0;
        do_ack();
        do_eoi_set();

        // rotating vs fixed priority with lines 0 and 1 competing
        pulse_irq(5'b00011);
        sbq.push_back(8'hF0);
`ifdef INT_ARB_ROUND_ROBIN_EN
        sbq.push_back(8'hF2);
`else
        sbq.push_back(8'hF0);
`endif
        wait_req("t6a");
        do_ack();
        pulse_irq(5'b00001);
        check("t6_pending", 32'(bus.pending), 32'b00011);
        do_eoi_set();
        wait_req("t6b");
        do_ack();
        do_eoi_set();

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
